// File: rtl/sprite_io_regs.sv
// sprite_io_regs: IO-mapped sprite position block behind the stack CPU IO port.
//   The CPU writes sprite positions into shadow registers and then writes COMMIT.
//   At the next vblank the shadow registers are copied to the active registers
//   in one step, so the renderer never sees a half-updated set.
//   The block also provides a vblank flag and a 16-bit frame counter.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   io_addr             CPU IO address; io_addr[15:8] == BASE_HI selects this block
//   io_write            one-cycle write strobe, data taken from io_wr_data
//   io_rd_data          read data, combinational from io_addr
//   vblank_start        one-cycle pulse at the start of vblank
//   spr_x, spr_y        active coordinates, sprite i at [i*COORD_W +: COORD_W]
//   spr_en              active per-sprite enables
//   commit_done         one-cycle pulse in the cycle after a shadow->active copy
//
// Build option:
//   SPRITE_IO_READBACK_EN  when defined, the sprite X/Y and ENABLE offsets read
//                          back the shadow values; otherwise they read 0.
//
// Commit FSM:
//   state | meaning
//   IDLE  | no commit pending; vblank_start only updates FRAME and the flag
//   ARMED | COMMIT written; the next vblank_start copies shadow to active
module sprite_io_regs #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         NUM_SPRITES = 8,
  parameter int         COORD_W     = 10,
  parameter logic [7:0] BASE_HI     = 8'h80
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          io_addr,
  input  logic                           io_write,
  input  logic [DATA_WIDTH-1:0]          io_wr_data,
  output logic [DATA_WIDTH-1:0]          io_rd_data,
  input  logic                           vblank_start,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  output logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  output logic [NUM_SPRITES-1:0]         spr_en,
  output logic                           commit_done
);

  localparam int         SW         = NUM_SPRITES * COORD_W;
  localparam logic [7:0] OFF_STATUS = 8'hF0;
  localparam logic [7:0] OFF_FRAME  = 8'hF1;
  localparam logic [7:0] OFF_ENABLE = 8'hF2;
  localparam logic [7:0] OFF_COMMIT = 8'hF3;
  // Sprite registers occupy offsets 0 .. 2*NUM_SPRITES-1.
  localparam logic [7:0] SPR_END    = 8'(2 * NUM_SPRITES);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  logic            sel;
  logic [7:0]      off;
  logic            wr;
  logic            is_spr;
  logic [2:0]      spr_idx;
  logic            commit_wr;
  logic            do_copy;

  logic [SW-1:0]          shadow_x_q, shadow_x_d;
  logic [SW-1:0]          shadow_y_q, shadow_y_d;
  logic [NUM_SPRITES-1:0] shadow_en_q, shadow_en_d;
  logic [SW-1:0]          active_x_q, active_x_d;
  logic [SW-1:0]          active_y_q, active_y_d;
  logic [NUM_SPRITES-1:0] active_en_q, active_en_d;
  state_t                 state_q, state_d;
  logic                   commit_done_q, commit_done_d;
  logic                   vblank_flag_q, vblank_flag_d;
  logic [15:0]            frame_q, frame_d;

  // Data bits above the coordinate width are dropped by every register.
  logic unused_wr_bits;
  assign unused_wr_bits = ^io_wr_data[DATA_WIDTH-1:COORD_W];

  assign sel       = (io_addr[15:8] == BASE_HI);
  assign off       = io_addr[7:0];
  assign wr        = io_write & sel;
  assign is_spr    = (off < SPR_END);
  assign spr_idx   = off[3:1];
  assign commit_wr = wr && (off == OFF_COMMIT);
  // A COMMIT written in the same cycle as vblank_start copies immediately.
  assign do_copy   = vblank_start && ((state_q == ARMED) || commit_wr);

  always_comb begin
    shadow_x_d    = shadow_x_q;
    shadow_y_d    = shadow_y_q;
    shadow_en_d   = shadow_en_q;
    active_x_d    = active_x_q;
    active_y_d    = active_y_q;
    active_en_d   = active_en_q;
    state_d       = state_q;
    commit_done_d = do_copy;
    vblank_flag_d = vblank_flag_q;
    frame_d       = frame_q + 16'(vblank_start);

    if (wr && is_spr) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (spr_idx == 3'(i)) begin
          if (off[0]) shadow_y_d[i*COORD_W +: COORD_W] = io_wr_data[COORD_W-1:0];
          else        shadow_x_d[i*COORD_W +: COORD_W] = io_wr_data[COORD_W-1:0];
        end
      end
    end
    if (wr && (off == OFF_ENABLE)) shadow_en_d = io_wr_data[NUM_SPRITES-1:0];

    // Copy takes the _q shadow values, so a same-cycle shadow write lands
    // in shadow only.
    if (do_copy) begin
      active_x_d  = shadow_x_q;
      active_y_d  = shadow_y_q;
      active_en_d = shadow_en_q;
      state_d     = IDLE;
    end else if (commit_wr) begin
      state_d     = ARMED;
    end

    // Set has priority over a same-cycle clear.
    if (vblank_start)                                   vblank_flag_d = 1'b1;
    else if (wr && (off == OFF_STATUS) && io_wr_data[0]) vblank_flag_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      shadow_en_q   <= '0;
      active_x_q    <= '0;
      active_y_q    <= '0;
      active_en_q   <= '0;
      state_q       <= IDLE;
      commit_done_q <= 1'b0;
      vblank_flag_q <= 1'b0;
      frame_q       <= '0;
    end else begin
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      shadow_en_q   <= shadow_en_d;
      active_x_q    <= active_x_d;
      active_y_q    <= active_y_d;
      active_en_q   <= active_en_d;
      state_q       <= state_d;
      commit_done_q <= commit_done_d;
      vblank_flag_q <= vblank_flag_d;
      frame_q       <= frame_d;
    end
  end

  always_comb begin
    io_rd_data = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: io_rd_data = DATA_WIDTH'({state_q == ARMED, vblank_flag_q});
        OFF_FRAME:  io_rd_data = DATA_WIDTH'(frame_q);
`ifdef SPRITE_IO_READBACK_EN
        OFF_ENABLE: io_rd_data = DATA_WIDTH'(shadow_en_q);
        default: begin
          if (is_spr) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
              if (spr_idx == 3'(i)) begin
                io_rd_data = off[0] ? DATA_WIDTH'(shadow_y_q[i*COORD_W +: COORD_W])
                                    : DATA_WIDTH'(shadow_x_q[i*COORD_W +: COORD_W]);
              end
            end
          end
        end
`else
        default: io_rd_data = '0;
`endif
      endcase
    end
  end

  assign spr_x       = active_x_q;
  assign spr_y       = active_y_q;
  assign spr_en      = active_en_q;
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_sprite_io_regs.sv
// Testbench for sprite_io_regs (default parameters: 8 sprites, 10-bit coords).
// Expected active-register contents are pushed to a scoreboard queue when a
// copying vblank is driven, and popped when commit_done is observed.
module tb_sprite_io_regs;

  localparam int NS = 8;
  localparam int CW = 10;
`ifdef SPRITE_IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [15:0]     io_addr = '0;
  logic            io_write = 1'b0;
  logic [15:0]     io_wr_data = '0;
  logic [15:0]     io_rd_data;
  logic            vblank_start = 1'b0;
  logic [NS*CW-1:0] spr_x;
  logic [NS*CW-1:0] spr_y;
  logic [NS-1:0]   spr_en;
  logic            commit_done;

  sprite_io_regs dut (
    .clock       (clock),
    .reset       (reset),
    .io_addr     (io_addr),
    .io_write    (io_write),
    .io_wr_data  (io_wr_data),
    .io_rd_data  (io_rd_data),
    .vblank_start(vblank_start),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
    .commit_done (commit_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NS*CW-1:0] x;
    logic [NS*CW-1:0] y;
    logic [NS-1:0]    en;
  } act_t;

  act_t        exp_q[$];
  logic [CW-1:0] m_sx[NS];
  logic [CW-1:0] m_sy[NS];
  logic [NS-1:0] m_en;
  logic [15:0]   exp_frame;
  int n_checks = 0;
  int n_fail = 0;
  int commit_cnt = 0;

  always @(posedge clock) if (commit_done === 1'b1) commit_cnt++;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sx[i] = '0;
      m_sy[i] = '0;
    end
    m_en = '0;
    exp_frame = '0;
    exp_q.delete();
  endtask

  task automatic model_write(input logic [15:0] a, input logic [15:0] d);
    if (a[15:8] == 8'h80) begin
      if (a[7:0] < 8'd16) begin
        if (a[0]) m_sy[a[3:1]] = d[CW-1:0];
        else      m_sx[a[3:1]] = d[CW-1:0];
      end else if (a[7:0] == 8'hF2) begin
        m_en = d[NS-1:0];
      end
    end
  endtask

  function automatic act_t snapshot();
    act_t s;
    for (int i = 0; i < NS; i++) begin
      s.x[i*CW +: CW] = m_sx[i];
      s.y[i*CW +: CW] = m_sy[i];
    end
    s.en = m_en;
    return s;
  endfunction

  // Drive one cycle of stimulus; called and returns at a falling edge.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                      input logic v, input logic exp_copy);
    if (v && exp_copy) exp_q.push_back(snapshot());
    if (w) model_write(a, d);
    if (v) exp_frame = exp_frame + 16'd1;
    io_addr = a;
    io_wr_data = d;
    io_write = w;
    vblank_start = v;
    @(negedge clock);
    io_write = 1'b0;
    vblank_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io_addr = 16'h8000;
    io_wr_data = 16'h03FF;
    io_write = 1'b1;
    vblank_start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    io_write = 1'b0;
    vblank_start = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [15:0] addrs[3];
    addrs[0] = 16'h80F0;
    addrs[1] = 16'h80F1;
    addrs[2] = 16'h80F2;
    reset = 1'b1;
    io_addr = 16'h8000;
    io_wr_data = 16'h0123;
    io_write = 1'b1;
    vblank_start = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    io_write = 1'b0;
    vblank_start = 1'b0;
    model_reset();
    foreach (addrs[k]) begin
      io_addr = addrs[k];
      #1;
      n_checks++;
      if (io_rd_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_read addr=%h got %h want 0000", addrs[k], io_rd_data);
      end
    end
    n_checks++;
    if (spr_x !== '0 || spr_y !== '0 || spr_en !== '0 || commit_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs x=%h y=%h en=%h done=%b want all 0",
               spr_x, spr_y, spr_en, commit_done);
    end
  endtask

  task automatic test_commit();
    act_t e;
    int c0;
    step(16'h8000, 16'h0123, 1, 0, 0);
    step(16'h8001, 16'hFC45, 1, 0, 0);
    step(16'h80F2, 16'h0001, 1, 0, 0);
    step(16'h80F3, 16'h0000, 1, 0, 0);
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0002) begin
      n_fail++; $display("FAIL armed_status got %h want 0002", io_rd_data);
    end
    n_checks++;
    if (spr_x !== '0 || spr_y !== '0 || spr_en !== '0) begin
      n_fail++; $display("FAIL active_before_vblank x=%h y=%h en=%h want 0", spr_x, spr_y, spr_en);
    end
    io_addr = 16'h8001; #1;
    n_checks++;
    if (io_rd_data !== (RB ? 16'h0045 : 16'h0000)) begin
      n_fail++; $display("FAIL readback_y0 got %h want %h", io_rd_data, RB ? 16'h0045 : 16'h0000);
    end
    io_addr = 16'h80F2; #1;
    n_checks++;
    if (io_rd_data !== (RB ? 16'h0001 : 16'h0000)) begin
      n_fail++; $display("FAIL readback_en got %h want %h", io_rd_data, RB ? 16'h0001 : 16'h0000);
    end
    c0 = commit_cnt;
    step(16'h0000, 16'h0000, 0, 1, 1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL commit_copy scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (commit_done !== 1'b1 || spr_x !== e.x || spr_y !== e.y || spr_en !== e.en) begin
        n_fail++;
        $display("FAIL commit_copy done=%b x=%h y=%h en=%h want done=1 x=%h y=%h en=%h",
                 commit_done, spr_x, spr_y, spr_en, e.x, e.y, e.en);
      end
    end
    @(negedge clock);
    n_checks++;
    if (commit_done !== 1'b0 || commit_cnt - c0 != 1) begin
      n_fail++; $display("FAIL commit_pulse done=%b pulses=%0d want done=0 pulses=1",
                         commit_done, commit_cnt - c0);
    end
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL status_after_copy got %h want 0001", io_rd_data);
    end
    io_addr = 16'h80F1; #1;
    n_checks++;
    if (io_rd_data !== exp_frame) begin
      n_fail++; $display("FAIL frame_after_copy got %h want %h", io_rd_data, exp_frame);
    end
  endtask

  task automatic test_same_cycle();
    act_t e;
    int c0;
    step(16'h8000, 16'h01FF, 1, 0, 0);
    step(16'h80F3, 16'h0000, 1, 0, 0);
    c0 = commit_cnt;
    // Shadow X write lands together with the copying vblank.
    step(16'h8000, 16'h03AA, 1, 1, 1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL old_x_copy scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (commit_done !== 1'b1 || spr_x !== e.x || spr_y !== e.y || spr_en !== e.en) begin
        n_fail++;
        $display("FAIL old_x_copy done=%b x=%h en=%h want done=1 x=%h en=%h",
                 commit_done, spr_x, spr_en, e.x, e.en);
      end
    end
    step(16'h0000, 16'h0000, 0, 1, 0);
    @(negedge clock);
    n_checks++;
    if (spr_x[CW-1:0] !== 10'h1FF || commit_cnt - c0 != 1) begin
      n_fail++; $display("FAIL no_copy_idle x0=%h pulses=%0d want x0=1ff pulses=1",
                         spr_x[CW-1:0], commit_cnt - c0);
    end
    // COMMIT and vblank_start together while IDLE.
    step(16'h80F3, 16'h0000, 1, 1, 1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL commit_with_vblank scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (commit_done !== 1'b1 || spr_x !== e.x || spr_y !== e.y || spr_en !== e.en) begin
        n_fail++;
        $display("FAIL commit_with_vblank done=%b x=%h en=%h want done=1 x=%h en=%h",
                 commit_done, spr_x, spr_en, e.x, e.en);
      end
    end
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL idle_after_same_cycle got %h want 0001", io_rd_data);
    end
    io_addr = 16'h8000; #1;
    n_checks++;
    if (io_rd_data !== (RB ? 16'h03AA : 16'h0000)) begin
      n_fail++; $display("FAIL shadow_x_new got %h want %h", io_rd_data, RB ? 16'h03AA : 16'h0000);
    end
  endtask

  task automatic test_flag_race();
    step(16'h80F0, 16'h0001, 1, 0, 0);
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL flag_clear got %h want 0000", io_rd_data);
    end
    step(16'h80F0, 16'h0001, 1, 1, 0);
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL flag_set_wins got %h want 0001", io_rd_data);
    end
    step(16'h80F0, 16'h0000, 1, 0, 0);
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL flag_write0_keeps got %h want 0001", io_rd_data);
    end
  endtask

  task automatic test_frame_wrap();
    int c0;
    do_reset();
    c0 = commit_cnt;
    vblank_start = 1'b1;
    repeat (65535) @(negedge clock);
    vblank_start = 1'b0;
    exp_frame = 16'hFFFF;
    io_addr = 16'h80F1; #1;
    n_checks++;
    if (io_rd_data !== exp_frame) begin
      n_fail++; $display("FAIL frame_max got %h want %h", io_rd_data, exp_frame);
    end
    step(16'h0000, 16'h0000, 0, 1, 0);
    io_addr = 16'h80F1; #1;
    n_checks++;
    if (io_rd_data !== 16'h0000 || exp_frame !== 16'h0000) begin
      n_fail++; $display("FAIL frame_wrap got %h want 0000", io_rd_data);
    end
    @(negedge clock);
    n_checks++;
    if (commit_cnt != c0 || spr_x !== '0 || spr_en !== '0) begin
      n_fail++; $display("FAIL frame_no_copy pulses=%0d x=%h want pulses=0 x=0",
                         commit_cnt - c0, spr_x);
    end
  endtask

  task automatic test_reset_armed();
    int c0;
    step(16'h8000, 16'h0111, 1, 0, 0);
    step(16'h80F2, 16'h00FF, 1, 0, 0);
    step(16'h80F3, 16'h0000, 1, 0, 0);
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0003) begin
      n_fail++; $display("FAIL armed_before_reset got %h want 0003", io_rd_data);
    end
    do_reset();
    c0 = commit_cnt;
    step(16'h0000, 16'h0000, 0, 1, 0);
    @(negedge clock);
    n_checks++;
    if (spr_x !== '0 || spr_y !== '0 || spr_en !== '0 || commit_cnt != c0) begin
      n_fail++; $display("FAIL reset_abandons x=%h en=%h pulses=%0d want 0",
                         spr_x, spr_en, commit_cnt - c0);
    end
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL status_after_reset_vblank got %h want 0001", io_rd_data);
    end
  endtask

  task automatic test_unmapped();
    act_t e;
    logic [15:0] addrs[3];
    addrs[0] = 16'h7F00;
    addrs[1] = 16'h8010;
    addrs[2] = 16'h7FF0;
    step(16'h7F00, 16'h0155, 1, 0, 0);
    step(16'h8010, 16'h0155, 1, 0, 0);
    step(16'h80F1, 16'h1234, 1, 0, 0);
    step(16'h7FF3, 16'h0000, 1, 0, 0);
    io_addr = 16'h80F0; #1;
    n_checks++;
    if (io_rd_data !== 16'h0001) begin
      n_fail++; $display("FAIL foreign_commit_ignored got %h want 0001", io_rd_data);
    end
    foreach (addrs[k]) begin
      io_addr = addrs[k];
      #1;
      n_checks++;
      if (io_rd_data !== 16'h0000) begin
        n_fail++; $display("FAIL unmapped_read addr=%h got %h want 0000", addrs[k], io_rd_data);
      end
    end
    step(16'h80F3, 16'h0000, 1, 0, 0);
    step(16'h0000, 16'h0000, 0, 1, 1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL unmapped_copy scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (commit_done !== 1'b1 || spr_x !== e.x || spr_y !== e.y || spr_en !== e.en) begin
        n_fail++;
        $display("FAIL unmapped_copy done=%b x=%h y=%h want done=1 x=%h y=%h",
                 commit_done, spr_x, spr_y, e.x, e.y);
      end
    end
    io_addr = 16'h80F1; #1;
    n_checks++;
    if (io_rd_data !== exp_frame) begin
      n_fail++; $display("FAIL frame_readonly got %h want %h", io_rd_data, exp_frame);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit();
    test_same_cycle();
    test_flag_race();
    test_frame_wrap();
    test_reset_armed();
    test_unmapped();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_io_regs.md
Name: sprite_io_regs

Overview:
- Memory-mapped IO slave directly downstream of the stack CPU's IO port.
- Decodes CPU IO reads and writes, holds double-buffered sprite position registers and a frame counter.
- Presents vblank-synchronised active sprite positions to the sprite renderer.
- The CPU sees a tear-free sprite update: it fills the shadow registers, writes COMMIT, and the copy to active happens at the next vblank.

Parameters:
- DATA_WIDTH, 16, CPU data/address width.
- NUM_SPRITES, 8, number of sprites (1..8).
- COORD_W, 10, width of each X/Y coordinate.
- BASE_HI, 8'h80, value of io_addr[15:8] that selects this block.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- io_addr  in  DATA_WIDTH  CPU IO address
- io_write  in  1  CPU IO write strobe, one cycle per store
- io_wr_data  in  DATA_WIDTH  CPU IO write data
- io_rd_data  out  DATA_WIDTH  read data, combinational from io_addr
- vblank_start  in  1  single-cycle pulse from video timing at start of vblank
- spr_x  out  NUM_SPRITES*COORD_W  active X values, sprite i at [i*COORD_W +: COORD_W]
- spr_y  out  NUM_SPRITES*COORD_W  active Y values, same packing
- spr_en  out  NUM_SPRITES  active per-sprite enable
- commit_done  out  1  one-cycle pulse in the cycle after an active update

Behaviour:
- Select:
  - sel = (io_addr[15:8] == BASE_HI).
  - Offset is off = io_addr[7:0].
  - Writes are ignored when sel = 0.
  - Reads return 0 when sel = 0.
- Register map (by off):
  - 2*i: shadow X of sprite i.
  - 2*i+1: shadow Y of sprite i.
  - 0xF0 STATUS: bit0 vblank_flag, bit1 commit_pending; write 1 to bit0 clears the flag.
  - 0xF1 FRAME: 16-bit frame count, read-only.
  - 0xF2 ENABLE: shadow enable, low NUM_SPRITES bits.
  - 0xF3 COMMIT: any write arms a commit.
- Unmapped offsets, and sprite offsets for i >= NUM_SPRITES: read 0, writes ignored.
- Coordinate width rules:
  - Writes keep io_wr_data[COORD_W-1:0]; upper bits are discarded.
  - Reads zero-extend to DATA_WIDTH.
- Read latency: io_rd_data is combinational (0-cycle), because the CPU captures it on the same edge. Reads have no side effects.
- Write latency: a shadow write is visible on io_rd_data in the cycle after io_write.
- Commit FSM, two states:
  - IDLE: a COMMIT write moves to ARMED (commit_pending = 1).
  - ARMED: on vblank_start, copy all shadow X/Y/ENABLE to active, return to IDLE, and pulse commit_done in the next cycle.
  - A COMMIT write while ARMED stays ARMED; there is no double copy.
  - vblank_start while IDLE: no copy.
  - COMMIT write in the same cycle as vblank_start in IDLE: copy happens this edge, final state IDLE.
  - Shadow write in the same cycle as the copy: active receives the pre-write shadow value; the new value lands in shadow only.
- vblank_flag:
  - Set by vblank_start.
  - Cleared by a STATUS write with bit0 = 1.
  - If set and clear occur in the same cycle, set wins (flag = 1).
- FRAME: increments by 1 on every vblank_start and wraps 0xFFFF -> 0x0000.
- Active outputs: spr_x, spr_y and spr_en change only on a commit copy or on reset.
- Reset (synchronous, clock edge with reset = 1):
  - All shadow and active registers = 0, so spr_x = 0, spr_y = 0, spr_en = 0.
  - FSM = IDLE, commit_done = 0, vblank_flag = 0, FRAME = 0.
  - Reset mid-ARMED abandons the pending commit.
  - Reset has priority over simultaneous io_write and vblank_start.

Optional Feature:
- Macro: SPRITE_IO_READBACK_EN.
- When defined: sprite X/Y offsets and ENABLE read back the shadow values.
- When undefined: those offsets read 0 (write-only registers, smaller read mux). STATUS and FRAME read normally in both cases.

Test Plan:
- Reset, then read 0x80F0, 0x80F1, 0x80F2 -> all 0; spr_x = spr_y = 0; spr_en = 0; commit_done = 0.
- Write 0x8000 = 0x0123, 0x8001 = 0xFC45, 0x80F2 = 0x0001, COMMIT; then pulse vblank_start:
  - spr_x[9:0] = 0x123 and spr_y[9:0] = 0x045 only after the pulse.
  - spr_en[0] = 1; commit_done pulses once, one cycle later.
  - STATUS reads 0x0001.
- With SPRITE_IO_READBACK_EN: read 0x8001 -> 0x0045. Without: read 0x8001 -> 0x0000.
- COMMIT write and vblank_start in the same cycle while a shadow X write is also pending:
  - Copy occurs with the old X value.
  - Next vblank with no COMMIT: no copy.
- Set and clear of vblank_flag in the same cycle (write 0x80F0 = 1 together with vblank_start) -> flag reads 1.
- 65536 vblank_start pulses -> FRAME reads 0x0000.
- Assert reset while ARMED, then vblank_start -> no copy, outputs stay 0.
- Writes to 0x7F00 and to 0x8010 with NUM_SPRITES = 8 -> no state change; reads of both return 0.
